// File: rtl/radix4_stride_gather.sv
// Ping-pong reorder buffer: gathers natural-order complex samples into
// stride-N/4 quadruples for a four-input radix-4 butterfly.
module radix4_stride_gather #(
  parameter  int N  = 16,
  localparam int GW = $clog2(N / 4),
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_real,
  input  logic [31:0]   in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_0_real,
  output logic [31:0]   out_1_real,
  output logic [31:0]   out_2_real,
  output logic [31:0]   out_3_real,
  output logic [31:0]   out_0_imag,
  output logic [31:0]   out_1_imag,
  output logic [31:0]   out_2_imag,
  output logic [31:0]   out_3_imag,
  output logic [GW-1:0] out_group,
  output logic          out_last
);

  // Both banks share one array; the bank bit is the address MSB.
  logic [63:0]   mem [0:2*N-1];

  logic          wbank;
  logic [AW-1:0] wcnt;
  logic          rbank;
  logic [GW-1:0] rcnt;
  logic [1:0]    bank_full;

  logic          accept;
  logic          handshake;
  logic          wr_last;
  logic          rd_last;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;
  logic [63:0]   rd [4];

  assign in_ready  = !bank_full[wbank];
  assign out_valid = bank_full[rbank];
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign wr_last   = (wcnt == AW'(N - 1));
  assign rd_last   = (rcnt == GW'(N / 4 - 1));
  assign set_mask  = (accept && wr_last) ? (2'b01 << wbank) : 2'b00;
  assign clr_mask  = (handshake && rd_last) ? (2'b01 << rbank) : 2'b00;

  always_ff @(posedge clk) begin
    if (accept) mem[{wbank, wcnt}] <= {in_real, in_imag};
  end

  // Address rcnt + j*N/4 is just j concatenated above rcnt.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      rd[j] = out_valid ? mem[{rbank, 2'(j), rcnt}] : 64'd0;
    end
  end

  assign out_0_real = rd[0][63:32];
  assign out_0_imag = rd[0][31:0];
  assign out_1_real = rd[1][63:32];
  assign out_1_imag = rd[1][31:0];
  assign out_2_real = rd[2][63:32];
  assign out_2_imag = rd[2][31:0];
  assign out_3_real = rd[3][63:32];
  assign out_3_imag = rd[3][31:0];
  assign out_group  = out_valid ? rcnt : '0;
  assign out_last   = out_valid && rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank     <= 1'b0;
      wcnt      <= '0;
      rbank     <= 1'b0;
      rcnt      <= '0;
      bank_full <= 2'b00;
    end else begin
      if (accept) begin
        if (wr_last) begin
          wbank <= ~wbank;
          wcnt  <= '0;
        end else begin
          wcnt  <= wcnt + 1'b1;
        end
      end
      if (handshake) begin
        if (rd_last) begin
          rbank <= ~rbank;
          rcnt  <= '0;
        end else begin
          rcnt  <= rcnt + 1'b1;
        end
      end
      // Set and clear always target different banks, so both apply.
      bank_full <= (bank_full | set_mask) & ~clr_mask;
    end
  end

endmodule

// File: doc/radix4_stride_gather.md
# radix4_stride_gather

Input reorder buffer that sits directly upstream of the radix-4 butterfly linear-combination stage in the approximate FFT datapath. It accepts one complex IEEE-754 single-precision sample per cycle in natural order. It regroups each N-sample frame into N/4 stride-N/4 quadruples {x[k], x[k+N/4], x[k+N/2], x[k+3N/4]} and presents each quadruple in parallel to the four-input butterfly. Storage is ping-pong double-buffered, so a new frame can be written while the previous one drains.

## Interface
- N, 16, frame length in complex samples; power of 2, N ≥ 8.
- GW, log2(N/4), width of the group index (derived, not overridden).

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample this cycle
- in_real  in  32  sample real part, float32 bit pattern
- in_imag  in  32  sample imaginary part, float32 bit pattern
- out_valid  out  1  quadruple on output ports is valid
- out_ready  in  1  butterfly consumes the quadruple this cycle
- out_0_real … out_3_real  out  32 each  real parts of x[k], x[k+N/4], x[k+N/2], x[k+3N/4]
- out_0_imag … out_3_imag  out  32 each  imaginary parts, same order
- out_group  out  GW  k, index of the current quadruple within the frame
- out_last  out  1  high with the final quadruple (k = N/4-1) of a frame

## Operation
- Storage: two banks, each holding N complex words. Bits pass through untouched; there is no arithmetic.
- Write side state:
  - wbank (1 bit), wcnt (log2 N bits), bank_full[1:0].
  - in_ready = !bank_full[wbank].
  - Accept occurs when in_valid && in_ready. The sample is written to bank wbank, address wcnt, and wcnt increments.
  - On the accept where wcnt = N-1: set bank_full[wbank], toggle wbank, wrap wcnt to 0.
- Read side state:
  - rbank (1 bit), rcnt (GW bits).
  - out_valid = bank_full[rbank].
  - out_j = bank rbank, address rcnt + j·N/4, for j = 0..3.
  - out_group = rcnt; out_last = out_valid && (rcnt = N/4-1).
  - Handshake occurs when out_valid && out_ready, and increments rcnt.
  - On the handshake where rcnt = N/4-1: clear bank_full[rbank], toggle rbank, wrap rcnt to 0.
- Data, out_group and out_last outputs are forced to 0 whenever out_valid is low.
- Simultaneous events:
  - A set of bank_full on one bank and a clear on the other bank in the same cycle both take effect.
  - The write side never targets a full bank, so the drain bank is never overwritten.
- A sample offered while in_ready is low is not accepted. The source holds in_valid and the data until accepted.
- Output data, out_group and out_last stay stable while out_valid && !out_ready.
- Frames are implicit: after reset, every N consecutive accepted samples form one frame.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - wbank = rbank = 0, wcnt = rcnt = 0, bank_full = 0.
  - in_ready = 1, out_valid = 0, every data output = 0, out_group = 0, out_last = 0.
  - Bank contents are not reset.
- Reset mid-frame discards partial and full frames. The first sample accepted after reset is x[0] of a new frame.
- Latency:
  - out_valid rises on the clock edge that accepts sample N-1 of a frame. It is visible in the following cycle.
  - Quadruple 0 is available in that cycle.
- Throughput:
  - The write side accepts 1 sample/cycle.
  - The read side delivers 1 quadruple/cycle with out_ready high.
  - A frame drains in N/4 cycles, fewer than the N cycles needed to fill the other bank. Continuous input therefore never stalls when out_ready is held high.
- Backpressure: with both banks full, in_ready is low until the first drain handshake of rcnt = N/4-1. in_ready is high again the cycle after that edge.

## Test plan
- N=16, continuous input x[i] with real = 32'h0000_0000+i and imag = 32'h8000_0000+i, out_ready=1 -> out_valid is first high in the cycle after the 16th accept.
  - Group 0 = real {0,4,8,12}, imag {8000_0000,…04,…08,…0C}.
  - Group 3 = {3,7,11,15} with out_last=1.
  - out_valid is low again after 4 cycles.
- Three back-to-back frames with out_ready=1 -> in_ready stays 1 throughout. Output groups appear in order with no gaps between frames beyond the fill time.
- out_ready=0, feed 40 samples -> in_ready drops after accept 32. Samples 32..39 are held.
  - Outputs remain frame-0 group 0 and stay stable.
  - Raise out_ready: after 4 handshakes, in_ready returns and sample 32 is accepted.
- in_valid toggled 1-0-1-0 during a frame and out_ready toggled randomly -> group contents are identical to the gap-free case, and no group is skipped or duplicated.
- rst_n pulsed low asynchronously after 10 samples of frame 0 -> all outputs read 0 immediately and in_ready=1.
  - The next 16 samples form a complete frame whose group 0 is post-reset samples {0,4,8,12}.
- Reset asserted while a full bank is draining at rcnt=2 -> out_valid=0 with no further groups. The read side restarts at rbank=0, rcnt=0.
